// File: rtl/boot_loader_if.sv
// Byte-stream input and RAM write bus of the boot loader.
// The loader consumes the stream and drives the bus through the slave modport.
interface boot_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/boot_loader.sv
// Receives a framed byte-serial program image (sync, length, data, checksum) and writes it
// into the Cpu RAM from word 0 upward; releases the Cpu reset only after a verified image.
module boot_loader #(
    parameter int         DATA_WIDTH = 16,
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] SYNC_BYTE  = 8'h55
) (
    input  logic          clk,
    input  logic          rst,
    boot_loader_if.slave  bus,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          error
);
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int BCW       = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int MAX_WORDS = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t                state_r;
    logic [7:0]            word_len_r;
    logic [7:0]            word_idx_r;
    logic [BCW-1:0]        byte_cnt_r;
    logic [7:0]            chk_r;
    logic [DATA_WIDTH-1:0] word_sr_r;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] word_next_s;

    // Big-endian word assembly: earlier bytes end up in the upper bits.
    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                       input logic [7:0] b);
        return (w << 4'd8) | DATA_WIDTH'(b);
    endfunction

    assign bus.in_ready = (state_r != DONE);
    assign accept_s     = bus.in_valid && bus.in_ready;
    assign word_next_s  = shift_in(word_sr_r, bus.in_data);

    // Frame parser, RAM write port and status outputs, all advanced on accepted bytes only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            word_len_r    <= 8'd0;
            word_idx_r    <= 8'd0;
            byte_cnt_r    <= '0;
            chk_r         <= 8'd0;
            word_sr_r     <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_rst       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            if (accept_s) begin
                case (state_r)
                    IDLE: begin
                        if (bus.in_data == SYNC_BYTE) begin
                            state_r <= LEN;
                            busy    <= 1'b1;
                        end
                    end
                    LEN: begin
                        word_idx_r <= 8'd0;
                        byte_cnt_r <= '0;
                        chk_r      <= 8'd0;
                        word_len_r <= bus.in_data;
                        if (int'(bus.in_data) > MAX_WORDS) begin
                            state_r <= ERROR;
                            busy    <= 1'b0;
                            error   <= 1'b1;
                        end else if (bus.in_data == 8'd0) begin
                            state_r <= CHECK;
                        end else begin
                            state_r <= DATA;
                        end
                    end
                    DATA: begin
                        word_sr_r <= word_next_s;
                        chk_r     <= chk_r + bus.in_data;
                        if (byte_cnt_r == BCW'(BYTES - 1)) begin
                            byte_cnt_r    <= '0;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= ADDR_WIDTH'(word_idx_r);
                            bus.mem_wdata <= word_next_s;
                            word_idx_r    <= word_idx_r + 8'd1;
                            if (word_idx_r == word_len_r - 8'd1) begin
                                state_r <= CHECK;
                            end
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 1'b1;
                        end
                    end
                    CHECK: begin
                        busy <= 1'b0;
                        if (bus.in_data == chk_r) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b1;
                        end else begin
                            state_r <= ERROR;
                            error   <= 1'b1;
                        end
                    end
                    ERROR: begin
                        if (bus.in_data == SYNC_BYTE) begin
                            state_r <= LEN;
                            error   <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_r <= DONE;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        error   <= 1'b0;
                        cpu_rst <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: good/bad frames, garbage, bubbles, empty image,
// oversize length on a 2-bit address instance, and mid-frame reset.
module tb_boot_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    boot_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus1 ();
    boot_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) bus2 ();

    logic cpu_rst1, busy1, done1, error1;
    logic cpu_rst2, busy2, done2, error2;

    boot_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .SYNC_BYTE(8'h55)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .cpu_rst(cpu_rst1), .busy(busy1), .done(done1), .error(error1)
    );

    boot_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .SYNC_BYTE(8'h55)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .cpu_rst(cpu_rst2), .busy(busy2), .done(done2), .error(error2)
    );

    int total = 0;
    int bad   = 0;
    logic [23:0] wr_q[$];
    int          wr2_cnt  = 0;
    logic [1:0]  wr2_last = 2'd0;

    // Write logger for each instance; sampled mid-cycle so each pulse is seen once.
    always @(negedge clk) if (bus1.mem_we === 1'b1) wr_q.push_back({bus1.mem_addr, bus1.mem_wdata});
    always @(negedge clk) if (bus2.mem_we === 1'b1) begin
        wr2_cnt  = wr2_cnt + 1;
        wr2_last = bus2.mem_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send1(input logic [7:0] b);
        bus1.in_valid = 1'b1;
        bus1.in_data  = b;
        @(posedge clk); #1;
    endtask

    task automatic idle1(input int n);
        bus1.in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send2(input logic [7:0] b);
        bus2.in_valid = 1'b1;
        bus2.in_data  = b;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int start, input bit bubbles);
        logic [7:0] g [7];
        g = '{8'h55, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
        for (int i = start; i < 7; i++) begin
            if (bubbles) idle1($urandom_range(0, 3));
            send1(g[i]);
        end
        idle1(1);
    endtask

    task automatic check_good(input string tag);
        logic [23:0] exp [2];
        exp = '{{8'h00, 16'h1234}, {8'h01, 16'hABCD}};
        chk({tag, "_nwr"}, wr_q.size(), 2);
        for (int i = 0; i < 2; i++)
            chk({tag, "_wr"}, (i < wr_q.size()) ? wr_q[i] : 24'hFFFFFF, exp[i]);
        chk({tag, "_done"}, done1, 1'b1);
        chk({tag, "_cpurst"}, cpu_rst1, 1'b1);
        chk({tag, "_err"}, error1, 1'b0);
        chk({tag, "_busy"}, busy1, 1'b0);
        chk({tag, "_rdy"}, bus1.in_ready, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        bus1.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
        rst = 1'b0;
        #2;
        chk({tag, "_we"}, bus1.mem_we, 1'b0);
        chk({tag, "_addr"}, bus1.mem_addr, 8'h00);
        chk({tag, "_wdata"}, bus1.mem_wdata, 16'h0000);
        chk({tag, "_cpurst"}, cpu_rst1, 1'b0);
        chk({tag, "_busy"}, busy1, 1'b0);
        chk({tag, "_done"}, done1, 1'b0);
        chk({tag, "_err"}, error1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        wr_q.delete();
    endtask

    initial begin
        rst           = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.in_data  = 8'h00;
        bus2.in_valid = 1'b0;
        bus2.in_data  = 8'h00;
        @(posedge clk); #1;
        do_reset("rst0");
        chk("rst0_rdy", bus1.in_ready, 1'b1);

        // Good frame with per-byte timing checks
        send1(8'h55); chk("g_busy_sync", busy1, 1'b1);
        send1(8'h02);
        send1(8'h12); chk("g_we_b0", bus1.mem_we, 1'b0);
        send1(8'h34);
        chk("g_we_w0", bus1.mem_we, 1'b1);
        chk("g_addr_w0", bus1.mem_addr, 8'h00);
        chk("g_data_w0", bus1.mem_wdata, 16'h1234);
        send1(8'hAB);
        chk("g_we_hold", bus1.mem_we, 1'b0);
        chk("g_data_hold", bus1.mem_wdata, 16'h1234);
        send1(8'hCD);
        chk("g_we_w1", bus1.mem_we, 1'b1);
        chk("g_addr_w1", bus1.mem_addr, 8'h01);
        chk("g_data_w1", bus1.mem_wdata, 16'hABCD);
        send1(8'hBE);
        chk("g_done_edge", done1, 1'b1);
        chk("g_cpurst_edge", cpu_rst1, 1'b1);
        idle1(1);
        check_good("good");
        send1(8'h55); idle1(1);
        chk("done_sticky", done1, 1'b1);
        chk("done_nobusy", busy1, 1'b0);

        // Bad checksum, then recovery on sync
        do_reset("rst1");
        send1(8'h55); send1(8'h02); send1(8'h12); send1(8'h34);
        send1(8'hAB); send1(8'hCD); send1(8'hBF);
        chk("bad_err", error1, 1'b1);
        chk("bad_done", done1, 1'b0);
        chk("bad_cpurst", cpu_rst1, 1'b0);
        chk("bad_nwr", wr_q.size(), 2);
        chk("bad_rdy", bus1.in_ready, 1'b1);
        wr_q.delete();
        send1(8'h55);
        chk("resync_err", error1, 1'b0);
        chk("resync_busy", busy1, 1'b1);
        send_frame(1, 1'b0);
        check_good("resend");

        // Leading garbage is discarded
        do_reset("rst2");
        send1(8'h00); chk("garb0_busy", busy1, 1'b0);
        send1(8'hFF); chk("garb1_busy", busy1, 1'b0);
        send1(8'h13); chk("garb2_busy", busy1, 1'b0);
        chk("garb_nwr", wr_q.size(), 0);
        send_frame(0, 1'b0);
        check_good("garbage");

        // Random bubbles between bytes
        do_reset("rst3");
        send_frame(0, 1'b1);
        check_good("bubble");

        // Empty image
        do_reset("rst4");
        send1(8'h55);
        send1(8'h00);
        chk("empty_busy", busy1, 1'b1);
        send1(8'h00);
        idle1(1);
        chk("empty_done", done1, 1'b1);
        chk("empty_cpurst", cpu_rst1, 1'b1);
        chk("empty_nwr", wr_q.size(), 0);

        // Mid-frame reset
        do_reset("rst5");
        send1(8'h55); send1(8'h02); send1(8'h12);
        chk("mid_busy", busy1, 1'b1);
        do_reset("midrst");
        send_frame(0, 1'b0);
        check_good("after_rst");

        // 2-bit address instance: length 5 exceeds 4 words, length 4 fills RAM
        send2(8'h55); send2(8'h05);
        chk("aw2_err", error2, 1'b1);
        chk("aw2_busy", busy2, 1'b0);
        chk("aw2_cpurst", cpu_rst2, 1'b0);
        chk("aw2_rdy", bus2.in_ready, 1'b1);
        send2(8'h55);
        chk("aw2_resync", error2, 1'b0);
        send2(8'h04);
        send2(8'h00); send2(8'h01); send2(8'h00); send2(8'h02);
        send2(8'h00); send2(8'h03); send2(8'h00); send2(8'h04);
        chk("aw2_busy_chk", busy2, 1'b1);
        send2(8'h0A);
        bus2.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("aw2_done", done2, 1'b1);
        chk("aw2_nwr", wr2_cnt, 4);
        chk("aw2_last", wr2_last, 2'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
